// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers pixel coordinates from hsync/vsync/valid, measures line and
// frame lengths, and declares lock after a run of frames matching the expected raster.
module vga_sync_rx #(
  parameter int unsigned HT          = 800,
  parameter int unsigned VT          = 525,
  parameter int unsigned HD          = 640,
  parameter int unsigned VD          = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       valid,
  output logic       px_valid,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       frame_start,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       err
);

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

  localparam logic [9:0] CntMax    = 10'h3ff;
  localparam logic [9:0] HtW       = 10'(HT);
  localparam logic [9:0] VtW       = 10'(VT);
  localparam logic [9:0] HdW       = 10'(HD);
  localparam logic [9:0] VdW       = 10'(VD);
  localparam logic [3:0] LockCount = 4'(LOCK_FRAMES);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CntMax) ? v : v + 10'd1;
  endfunction

  state_e     state_q, state_d;
  logic       hs_q, vs_q;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] xcnt_q, xcnt_d;
  logic [9:0] lcnt_q, lcnt_d;
  logic [9:0] act_q, act_d;
  logic       hs_seen_q, hs_seen_d;
  logic       frame_bad_q, frame_bad_d;
  logic [3:0] good_q, good_d;
  logic       err_d;
  logic       to_search;

  logic       hs_fall, vs_fall;
  logic [9:0] line_len_new, x_base, act_next, lcnt_next;
  logic       line_active, line_viol, frame_viol, timeout, viol;

  assign hs_fall = hs_q & ~hsync;
  assign vs_fall = vs_q & ~vsync;

  // Datapath: counters and the violation terms derived from them.
  always_comb begin
    line_len_new = sat_inc(hcnt_q);
    hcnt_d       = hs_fall ? 10'd0 : sat_inc(hcnt_q);
    x_base       = hs_fall ? 10'd0 : xcnt_q;
    xcnt_d       = valid ? sat_inc(x_base) : x_base;
    line_active  = hs_fall & (xcnt_q != 10'd0);
    act_next     = line_active ? sat_inc(act_q) : act_q;
    lcnt_next    = hs_fall ? sat_inc(lcnt_q) : lcnt_q;
    act_d        = vs_fall ? 10'd0 : act_next;
    lcnt_d       = vs_fall ? 10'd0 : lcnt_next;
    line_viol    = hs_fall & ((hs_seen_q & (line_len_new != HtW)) |
                              (line_active & (xcnt_q != HdW)));
    frame_viol   = vs_fall & ((lcnt_next != VtW) | (act_next != VdW));
    // Fires once, on the edge where hcnt climbs into saturation.
    timeout      = ~hs_fall & (hcnt_q == CntMax - 10'd1);
    viol         = line_viol | frame_viol | timeout;
  end

  // Lock FSM next-state.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    err_d     = 1'b0;
    to_search = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (timeout) begin
          to_search = 1'b1;
        end else if (vs_fall && hs_seen_q) begin
          state_d = StCheck;
          good_d  = 4'd0;
        end
      end
      StCheck: begin
        if (viol) begin
          err_d  = 1'b1;
          good_d = 4'd0;
          if (timeout) begin
            state_d   = StSearch;
            to_search = 1'b1;
          end
        end else if (vs_fall && !frame_bad_q) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 >= LockCount) begin
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (viol) begin
          err_d     = 1'b1;
          state_d   = StSearch;
          to_search = 1'b1;
        end
      end
      default: begin
        state_d   = StSearch;
        to_search = 1'b1;
      end
    endcase
    hs_seen_d   = to_search ? 1'b0 : (hs_fall | hs_seen_q);
    frame_bad_d = vs_fall ? 1'b0 : (frame_bad_q | viol);
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q     <= StSearch;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      hcnt_q      <= 10'd0;
      xcnt_q      <= 10'd0;
      lcnt_q      <= 10'd0;
      act_q       <= 10'd0;
      hs_seen_q   <= 1'b0;
      frame_bad_q <= 1'b0;
      good_q      <= 4'd0;
      px_valid    <= 1'b0;
      px_x        <= 10'd0;
      px_y        <= 10'd0;
      frame_start <= 1'b0;
      line_len    <= 10'd0;
      frame_lines <= 10'd0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hsync;
      vs_q        <= vsync;
      hcnt_q      <= hcnt_d;
      xcnt_q      <= xcnt_d;
      lcnt_q      <= lcnt_d;
      act_q       <= act_d;
      hs_seen_q   <= hs_seen_d;
      frame_bad_q <= frame_bad_d;
      good_q      <= good_d;
      px_valid    <= valid;
      px_x        <= x_base;
      px_y        <= act_q;
      frame_start <= vs_fall;
      if (hs_fall) line_len <= line_len_new;
      if (vs_fall) frame_lines <= lcnt_next;
      err         <= err_d;
    end
  end

  assign locked = (state_q == StLocked);

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receiver-side companion to the VGA timing generator: samples `hsync`, `vsync` and `valid` on the pixel clock and recovers per-pixel coordinates. It measures line and frame lengths and declares lock once the incoming timing matches the expected 640x480@60 raster for a programmable number of consecutive frames. It sits on the consumer side of the timing interface, in front of frame capture or self-check logic, and serves as an in-system timing checker for the generator.

## Interface
- `HT`, 800: expected clocks per line (hsync fall to hsync fall)
- `VT`, 525: expected lines per frame (hsync falls between vsync falls)
- `HD`, 640: expected `valid` clocks per active line
- `VD`, 480: expected active lines per frame
- `LOCK_FRAMES`, 2: consecutive good frames required for lock (1..15)
- `pclk` input 1: pixel clock; all logic on posedge
- `reset` input 1: asynchronous, active-low reset
- `hsync` input 1: active-low line sync, synchronous to `pclk`
- `vsync` input 1: active-low frame sync, synchronous to `pclk`
- `valid` input 1: active-pixel qualifier
- `px_valid` output 1: registered copy of `valid`
- `px_x` output 10: column of the pixel flagged by `px_valid`
- `px_y` output 10: row of the pixel flagged by `px_valid`
- `frame_start` output 1: one-cycle pulse per detected vsync fall
- `line_len` output 10: last measured line length in clocks
- `frame_lines` output 10: last measured lines per frame
- `locked` output 1: timing matches parameters
- `err` output 1: one-cycle pulse on any timing violation while in CHECK or LOCKED

## Operation
- Edge detect: `hs_q`/`vs_q` register the previous sample and reset to 1. hs_fall = hs_q & ~hsync. vs_fall = vs_q & ~vsync.
- `hcnt` (10 b) increments every clock and saturates at 1023. On hs_fall it loads 0 and `line_len` captures `hcnt + 1`. `hs_seen` sets on the first hs_fall after reset or after entry to SEARCH.
- `xcnt` counts `valid` clocks and clears on hs_fall. On hs_fall, if `xcnt` is nonzero, the ended line was active: `act_lines` increments, and the line is a violation unless `xcnt == HD`.
- `lcnt` increments on hs_fall. On vs_fall, `frame_lines` captures `lcnt` (plus 1 if hs_fall occurs in the same cycle), then `lcnt` and `act_lines` clear.
- Pixel path: `px_valid <= valid`, `px_x <= xcnt`, `px_y <= act_lines`. The first active pixel of a frame reads (0,0).
- Line violation: hs_fall with `hs_seen` set and `line_len != HT`, or an active line with `xcnt != HD`.
- Frame violation: vs_fall with `frame_lines != VT` or `act_lines != VD`.
- Timeout: `hcnt` reaches 1023. This counts as a violation.
- Lock FSM states:
  - SEARCH: counters run, no checks, `locked` = 0. The first vs_fall with `hs_seen` set moves to CHECK with good_cnt = 0.
  - CHECK: any violation pulses `err`, clears good_cnt and stays in CHECK. A violation-free frame increments good_cnt at vs_fall; when good_cnt reaches `LOCK_FRAMES`, move to LOCKED.
  - LOCKED: `locked` = 1. Any violation pulses `err` and moves to SEARCH, clearing `hs_seen`.
  - Timeout in any state moves to SEARCH, with `err` pulsing only from CHECK or LOCKED.
- The frame under test starts at the vs_fall that enters CHECK. The partial frame before that is ignored.
- Simultaneous hs_fall and vs_fall in one cycle: the line is counted into the ending frame, then counters clear.

## Timing
- Reset values are 0 for every output and counter. `hs_q`, `vs_q` and `hs_seen`'s clear state are as stated above, and the FSM resets to SEARCH.
- The pixel path has a latency of 1 clock: `px_*` at cycle n+1 reflect inputs at cycle n.
- `frame_start`, `line_len`, `frame_lines`, `err` and `locked` update on the clock edge that samples the detected edge, i.e. 1 clock after the first low sample is presented.
- `locked` rises on the same edge that captures the `LOCK_FRAMES`-th good vs_fall. It falls on the edge that samples the violation.
- Asserting reset mid-frame clears everything immediately. After release, the block needs one vs_fall to enter CHECK, then `LOCK_FRAMES` good frames.
- Counters never wrap: `hcnt` saturates at 1023, and `lcnt`/`xcnt` saturate at 1023.

## Test plan
- Nominal generator stimulus (800x525, hsync low 96 clocks, `valid` 640x480), from reset: `frame_start` pulses every 420000 clocks; `locked` rises at the 3rd vs_fall (1 to enter CHECK + 2 good frames); `err` never pulses; `line_len` = 800; `frame_lines` = 525.
- While locked, the first active pixel after vsync gives `px_x`=0, `px_y`=0 one clock later. The last active pixel gives `px_x`=639, `px_y`=479.
- While locked, stretch one line to 801 clocks: `err` pulses once and `locked` drops at that hs_fall. Lock re-acquires 3 vs_falls later.
- While locked, drop one valid clock so a line has 639 active pixels: `err` pulses and `locked` falls at that line's hs_fall.
- Hold hsync high for 1100 clocks while in CHECK: `err` pulses at `hcnt` = 1023, the FSM enters SEARCH, and `locked` stays 0.
- Assert reset mid-frame for 3 clocks while locked: all outputs are 0 during reset. After release, `locked` returns only after a fresh 3-vs_fall sequence.
